// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array edge feeder.
package systolic_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefArrayN    = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

  // Bit offset of lane `lane` in a bus of `width`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// N x N operand register file: one full-row write port and one element read per lane.
module systolic_operand_buf
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ARRAY_N    = DefArrayN,
  localparam int unsigned IDX_W     = $clog2(ARRAY_N),
  localparam int unsigned BUS_W     = DATA_WIDTH * ARRAY_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_row,
  input  logic [BUS_W-1:0]         wr_data,
  input  logic [IDX_W*ARRAY_N-1:0] rd_row,
  input  logic [IDX_W*ARRAY_N-1:0] rd_col,
  output logic [BUS_W-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [ARRAY_N][ARRAY_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(ARRAY_N); r++) begin
        for (int c = 0; c < int'(ARRAY_N); c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < int'(ARRAY_N); c++) begin
        mem_q[wr_row][c] <= wr_data[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int l = 0; l < int'(ARRAY_N); l++) begin
      rd_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] =
          mem_q[rd_row[l*IDX_W +: IDX_W]][rd_col[l*IDX_W +: IDX_W]];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads A and B row by row, then replays them diagonally skewed onto the array edges.
// Optional pass counter (feed_count) enabled by defining FEEDER_PERF_CNT_EN.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ARRAY_N    = DefArrayN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*ARRAY_N-1:0] in_a,
  input  logic [DATA_WIDTH*ARRAY_N-1:0] in_b,
  output logic [DATA_WIDTH*ARRAY_N-1:0] left_out,
  output logic [DATA_WIDTH*ARRAY_N-1:0] top_out,
  output logic                          out_valid,
  output logic                          done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]                   feed_count
`endif
);

  localparam int unsigned IDX_W = $clog2(ARRAY_N);
  localparam int unsigned CNT_W = $clog2(2 * ARRAY_N);
  localparam int unsigned BUS_W = DATA_WIDTH * ARRAY_N;

  feeder_state_t state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d, step_q, step_d, drv_step;
  logic drive, wr_en, valid_q;
  logic [ARRAY_N-1:0] lane_ok;
  logic [IDX_W*ARRAY_N-1:0] a_rd_row, a_rd_col, b_rd_row, b_rd_col;
  logic [BUS_W-1:0] a_rd_data, b_rd_data, left_d, top_d, left_q, top_q;

  assign in_ready  = (state_q == LOAD);
  assign wr_en     = in_valid && in_ready;
  assign out_valid = valid_q;
  assign left_out  = left_q;
  assign top_out   = top_q;
  assign done      = (state_q == DONE);

  // drive/drv_step select which step the output registers capture on this edge.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    step_d     = step_q;
    drive      = 1'b0;
    drv_step   = '0;
    unique case (state_q)
      LOAD: begin
        if (wr_en) begin
          if (load_cnt_q == CNT_W'(ARRAY_N - 1)) begin
            state_d    = FEED;
            load_cnt_d = '0;
            step_d     = '0;
            drive      = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      FEED: begin
        if (step_q == CNT_W'(2 * ARRAY_N - 2)) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d   = step_q + 1'b1;
          drive    = 1'b1;
          drv_step = step_d;
        end
      end
      DONE: begin
        state_d    = LOAD;
        load_cnt_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end

  // Lane i reads A[i][t-i] and B[t-i][i]; out-of-window lanes are masked.
  always_comb begin
    int d;
    d        = 0;
    lane_ok  = '0;
    a_rd_row = '0;
    a_rd_col = '0;
    b_rd_row = '0;
    b_rd_col = '0;
    for (int i = 0; i < int'(ARRAY_N); i++) begin
      d          = int'(drv_step) - i;
      lane_ok[i] = drive && (d >= 0) && (d < int'(ARRAY_N));
      if (lane_ok[i]) begin
        a_rd_row[i*IDX_W +: IDX_W] = IDX_W'(i);
        a_rd_col[i*IDX_W +: IDX_W] = IDX_W'(d);
        b_rd_row[i*IDX_W +: IDX_W] = IDX_W'(d);
        b_rd_col[i*IDX_W +: IDX_W] = IDX_W'(i);
      end
    end
  end

  always_comb begin
    left_d = '0;
    top_d  = '0;
    for (int i = 0; i < int'(ARRAY_N); i++) begin
      if (lane_ok[i]) begin
        left_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
            a_rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        top_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
            b_rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      step_q     <= '0;
      valid_q    <= 1'b0;
      left_q     <= '0;
      top_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      step_q     <= step_d;
      valid_q    <= drive;
      left_q     <= left_d;
      top_q      <= top_d;
    end
  end

  systolic_operand_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_N    (ARRAY_N)
  ) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (load_cnt_q[IDX_W-1:0]),
    .wr_data (in_a),
    .rd_row  (a_rd_row),
    .rd_col  (a_rd_col),
    .rd_data (a_rd_data)
  );

  systolic_operand_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_N    (ARRAY_N)
  ) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (load_cnt_q[IDX_W-1:0]),
    .wr_data (in_b),
    .rd_row  (b_rd_row),
    .rd_col  (b_rd_col),
    .rd_data (b_rd_data)
  );

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] feed_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_cnt_q <= '0;
    end else if (state_q == DONE) begin
      feed_cnt_q <= feed_cnt_q + 16'd1;
    end
  end

  assign feed_count = feed_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (N=4, DATA_WIDTH=8).
module tb_systolic_skew_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int BW = DW * N;
  localparam int STEPS = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic [BW-1:0] left_out, top_out;
  logic          out_valid, done;
`ifdef FEEDER_PERF_CNT_EN
  logic [15:0]   feed_count;
`endif

  systolic_skew_feeder #(
    .DATA_WIDTH (DW),
    .ARRAY_N    (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .left_out  (left_out),
    .top_out   (top_out),
    .out_valid (out_valid),
    .done      (done)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .feed_count (feed_count)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]  mat_a [N][N];
  logic [7:0]  mat_b [N][N];
  logic [63:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_valid = 1'b0;

  // Hand-computed skew for A[r][c]=16r+c+1, B[r][c]=0x80+4r+c; lane 3 is the top byte.
  logic [31:0] hand_l [STEPS] = '{32'h00000001, 32'h00001102, 32'h00211203, 32'h31221304,
                                  32'h32231400, 32'h33240000, 32'h34000000};
  logic [31:0] hand_t [STEPS] = '{32'h00000080, 32'h00008184, 32'h00828588, 32'h8386898C,
                                  32'h878A8D00, 32'h8B8E0000, 32'h8F000000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] model_step(input int t);
    logic [BW-1:0] l, tp;
    l  = '0;
    tp = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) begin
        l[i*DW +: DW]  = mat_a[i][t-i];
        tp[i*DW +: DW] = mat_b[t-i][i];
      end
    end
    return {l, tp};
  endfunction

  function automatic logic [BW-1:0] row_a(input int k);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = mat_a[k][i];
    return r;
  endfunction

  function automatic logic [BW-1:0] row_b(input int k);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = mat_b[k][i];
    return r;
  endfunction

  task automatic fill_s1();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[r][c] = 8'(16 * r + c + 1);
        mat_b[r][c] = 8'(8'h80 + 4 * r + c);
      end
  endtask

  task automatic fill_pass(input int p);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[r][c] = 8'(8'h40 * p + 4 * r + c + 3);
        mat_b[r][c] = 8'(8'hF0 - 8'h20 * p - 4 * r - c);
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[r][c] = 8'($urandom_range(1, 255));
        mat_b[r][c] = 8'($urandom_range(1, 255));
      end
  endtask

  task automatic push_hand();
    for (int t = 0; t < STEPS; t++) exp_q.push_back({hand_l[t], hand_t[t]});
  endtask

  task automatic push_model();
    for (int t = 0; t < STEPS; t++) exp_q.push_back(model_step(t));
  endtask

  // pat[p] is in_valid at presentation p (1 once p >= plen); returns the cycles used.
  task automatic do_load(input logic [15:0] pat, input int plen, input int nbeats,
                         output int cycles);
    int   k, g;
    logic v, acc;
    k = 0;
    g = 0;
    while (k < nbeats && g < 64) begin
      v        = (g < plen) ? pat[g] : 1'b1;
      in_valid = v;
      in_a     = v ? row_a(k) : {N{8'hEE}};
      in_b     = v ? row_b(k) : {N{8'hEE}};
      acc      = v && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    cycles   = g;
    if (k < nbeats) begin
      n_vec++;
      n_err++;
      $display("FAIL load_timeout: got %0d beats required %0d", k, nbeats);
    end
  endtask

  // Returns one cycle into the LOAD state following the DONE cycle.
  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL feed_drain: got %0d steps left required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_bus"}, {left_out, top_out}, 64'h0);
    check({name, "_ctl"}, {61'h0, out_valid, done, in_ready}, 64'h1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outs("reset_async");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected step per out_valid cycle; checks done and idle-zero buses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_feed: got out_valid=1 required 0 at %0t", $time);
        end else begin
          check("feed_step", {left_out, top_out}, exp_q.pop_front());
        end
      end else begin
        check("idle_zero", {left_out, top_out}, 64'h0);
      end
      check("done", {63'h0, done}, {63'h0, prev_valid & ~out_valid});
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset_state");
    rst_n = 1'b1;

    // Scenario 1: contiguous load, hand-computed feed.
    fill_s1();
    do_load(16'h0, 0, N, cyc);
    check("s1_load_cycles", 64'(cyc), 64'd4);
    check("s1_ready_low", {63'h0, in_ready}, 64'h0);
    push_hand();
    wait_drain();
    check("s1_ready_back", {63'h0, in_ready}, 64'h1);

    // Scenario 2: gapped in_valid 1,0,0,1,1,0,1.
    do_load(16'b1011001, 7, N, cyc);
    check("s2_load_cycles", 64'(cyc), 64'd7);
    push_hand();
    wait_drain();

    // Scenario 3: in_valid held through FEED and DONE with changing data.
    fill_pass(1);
    do_load(16'h0, 0, N, cyc);
    push_model();
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_a     = {N{8'(8'h55 + c)}};
      in_b     = {N{8'(8'hAA - c)}};
      check("s3_ready_low", {63'h0, in_ready}, 64'h0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("s3_ready_back", {63'h0, in_ready}, 64'h1);
    check("s3_drained", 64'(exp_q.size()), 64'd0);
    fill_pass(2);
    do_load(16'h0, 0, N, cyc);
    push_model();
    wait_drain();

    // Scenario 4: reset mid-LOAD, then mid-FEED after step 3.
    fill_pass(3);
    do_load(16'h0, 0, 2, cyc);
    pulse_reset();
    fill_s1();
    do_load(16'h0, 0, N, cyc);
    push_hand();
    wait_drain();
    do_load(16'h0, 0, N, cyc);
    push_hand();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    pulse_reset();
    fill_rand();
    do_load(16'h0, 0, N, cyc);
    push_model();
    wait_drain();

    // Scenario 5: three back-to-back passes, 12 cycles each.
    pulse_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (c % 12 == 0) fill_pass(c / 12);
      if (c % 12 < N) begin
        in_a = row_a(c % 12);
        in_b = row_b(c % 12);
      end else begin
        in_a = {N{8'hA5}};
        in_b = {N{8'h5A}};
      end
      check("s5_ready", {63'h0, in_ready}, {63'h0, 1'(c % 12 < N)});
      if (c % 12 == N - 1) push_model();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("s5_drained", 64'(exp_q.size()), 64'd0);
`ifdef FEEDER_PERF_CNT_EN
    check("s5_feed_count", 64'(feed_count), 64'd3);
`endif

    // Scenario 6: random operands against the model.
    for (int p = 0; p < 2; p++) begin
      fill_rand();
      do_load(16'b0110, 4, N, cyc);
      push_model();
      wait_drain();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
